spi_xfer_sequencer: RTL and testbench
=====================================

Name: spi_xfer_sequencer

Overview:
- Transfer controller between the SPI TX FIFO read port, the SPI shift engine and the RX FIFO write port.
- Pulls one word from the TX FIFO, frames it with chip-select, launches the shifter, then pushes the received word into the RX FIFO.
- Keeps CS asserted across back-to-back words when requested.
- Drives the FIFO request/response/acknowledge handshakes so that each word is pulled exactly once and pushed exactly once.

Parameters:
- DATA_WIDTH, 16, SPI word width.
- REG_WIDTH, 16, width of the transfer counter.
- CS_SETUP, 2, cycles from cs_n_o falling to shift_start_o (≥1).
- CS_IDLE, 2, minimum cycles cs_n_o stays high after a frame (≥1).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- enable_i  in  1  allow new frames
- cs_hold_i  in  1  keep CS low between consecutive words
- tx_empty_i  in  1  TX FIFO empty flag
- tx_req_o  out  1  TX FIFO read request
- tx_resp_i  in  1  TX FIFO read response (data valid)
- tx_data_i  in  DATA_WIDTH  TX FIFO read data
- tx_ack_o  out  1  TX FIFO acknowledge/pull, 1-cycle pulse
- rx_req_o  out  1  RX FIFO write request
- rx_data_o  out  DATA_WIDTH  RX FIFO write data
- rx_ack_i  in  1  RX FIFO write acknowledge
- shift_start_o  out  1  shifter start, 1-cycle pulse
- shift_data_o  out  DATA_WIDTH  word to shift out
- shift_done_i  in  1  shifter done, 1-cycle pulse
- shift_data_i  in  DATA_WIDTH  received word, valid with shift_done_i
- cs_n_o  out  1  chip select, active low
- busy_o  out  1  high in any state other than IDLE
- xfer_count_o  out  REG_WIDTH  completed words, wraps modulo 2^REG_WIDTH

Behaviour:
- Interface: one clock, clk_i; reset is synchronous and active-high, rst_i.
- All outputs are registered.
- Reset values: cs_n_o=1; all other outputs 0, including data buses and xfer_count_o; state=IDLE; CS_IDLE counter cleared.
- rst_i asserted in any state → next cycle cs_n_o=1, all requests/pulses 0, state=IDLE. It overrides every other input.
- IDLE: if enable_i & ~tx_empty_i & CS_IDLE satisfied → FETCH, tx_req_o=1.
- FETCH: hold tx_req_o=1 until tx_resp_i=1. On that cycle:
  - latch tx_data_i into shift_data_o;
  - next cycle: tx_req_o=0, tx_ack_o=1 for exactly one cycle;
  - → SETUP.
- SETUP:
  - cs_n_o already 0 (hold chaining): go straight to START.
  - Otherwise: drive cs_n_o=0 and count CS_SETUP cycles, then START.
- START: shift_start_o=1 for one cycle → SHIFT.
- SHIFT: wait for shift_done_i.
  - On done: latch shift_data_i into rx_data_o, set rx_req_o=1, increment xfer_count_o → STORE.
  - A shift_done_i arriving in any other state is ignored.
- STORE: hold rx_req_o=1 until rx_ack_i=1; rx_req_o drops the following cycle. A full RX FIFO therefore stalls the controller with CS held. Then → NEXT.
- NEXT:
  - enable_i & cs_hold_i & ~tx_empty_i → FETCH, cs_n_o stays 0.
  - Else → IDLE with cs_n_o=1; CS_IDLE counter starts.
- Requests are never re-asserted in the cycle after the response/ack is observed. This guarantees one pull and one push per word.
- enable_i deasserted mid-frame: the current word completes fully (fetch, shift, store), then CS is released and the block returns to IDLE.
- tx_empty_i rising while in FETCH has no effect; the request is already committed.
- Simultaneous tx_resp_i and rst_i: reset wins; no tx_ack_o is issued.
- xfer_count_o wraps from 2^REG_WIDTH-1 to 0 with no flag.

Test Plan:
- Single word: TX FIFO holds 0xA5C3, responder resp latency 1, shifter returns 0x1234 after 8 cycles → one tx_ack_o pulse, cs_n_o low ≥2 cycles before shift_start_o, shift_data_o=0xA5C3, RX pushed 0x1234, xfer_count_o=1, cs_n_o high ≥2 cycles after.
- Burst with cs_hold_i=1, 3 words 0x0001/0x0002/0x0003 → cs_n_o low continuously across all three, no SETUP wait on words 2–3, RX receives the echoed words in order, xfer_count_o=3.
- Burst with cs_hold_i=0, 2 words → cs_n_o deasserts between words for ≥CS_IDLE cycles, xfer_count_o=2.
- RX backpressure: rx_ack_i withheld 20 cycles → rx_req_o held 20 cycles, then exactly one push; no new fetch during stall; cs_n_o stays low.
- rst_i pulsed during SHIFT → next cycle cs_n_o=1, busy_o=0, xfer_count_o=0; a later shift_done_i produces no RX push.
- Counter wrap with REG_WIDTH=4: 17 words → xfer_count_o=1.

Source files
------------

// File: rtl/spi_xfer_sequencer.sv
// Word-level SPI transfer controller: pulls a word from the TX FIFO, frames it
// with chip-select, runs the shift engine and pushes the received word to the RX FIFO.
module spi_xfer_sequencer #(
  parameter int DATA_WIDTH = 16,
  parameter int REG_WIDTH  = 16,
  parameter int CS_SETUP   = 2,
  parameter int CS_IDLE    = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  enable_i,
  input  logic                  cs_hold_i,
  input  logic                  tx_empty_i,
  output logic                  tx_req_o,
  input  logic                  tx_resp_i,
  input  logic [DATA_WIDTH-1:0] tx_data_i,
  output logic                  tx_ack_o,
  output logic                  rx_req_o,
  output logic [DATA_WIDTH-1:0] rx_data_o,
  input  logic                  rx_ack_i,
  output logic                  shift_start_o,
  output logic [DATA_WIDTH-1:0] shift_data_o,
  input  logic                  shift_done_i,
  input  logic [DATA_WIDTH-1:0] shift_data_i,
  output logic                  cs_n_o,
  output logic                  busy_o,
  output logic [REG_WIDTH-1:0]  xfer_count_o
);

  localparam int SETUP_W = $clog2(CS_SETUP + 1);
  localparam int IDLE_W  = $clog2(CS_IDLE + 1);
  localparam logic [SETUP_W-1:0] SETUP_LAST = SETUP_W'(CS_SETUP - 1);
  localparam logic [IDLE_W-1:0]  IDLE_LOAD  = IDLE_W'(CS_IDLE);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_SETUP, S_START, S_SHIFT, S_STORE, S_NEXT
  } state_t;

  state_t                state_q, state_d;
  logic                  tx_req_q, tx_req_d;
  logic                  tx_ack_q, tx_ack_d;
  logic                  rx_req_q, rx_req_d;
  logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
  logic                  shift_start_q, shift_start_d;
  logic [DATA_WIDTH-1:0] shift_data_q, shift_data_d;
  logic                  cs_n_q, cs_n_d;
  logic                  busy_q, busy_d;
  logic [REG_WIDTH-1:0]  xfer_count_q, xfer_count_d;
  logic [SETUP_W-1:0]    setup_cnt_q, setup_cnt_d;
  logic [IDLE_W-1:0]     idle_cnt_q, idle_cnt_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= S_IDLE;
      tx_req_q      <= 1'b0;
      tx_ack_q      <= 1'b0;
      rx_req_q      <= 1'b0;
      rx_data_q     <= '0;
      shift_start_q <= 1'b0;
      shift_data_q  <= '0;
      cs_n_q        <= 1'b1;
      busy_q        <= 1'b0;
      xfer_count_q  <= '0;
      setup_cnt_q   <= '0;
      idle_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      tx_req_q      <= tx_req_d;
      tx_ack_q      <= tx_ack_d;
      rx_req_q      <= rx_req_d;
      rx_data_q     <= rx_data_d;
      shift_start_q <= shift_start_d;
      shift_data_q  <= shift_data_d;
      cs_n_q        <= cs_n_d;
      busy_q        <= busy_d;
      xfer_count_q  <= xfer_count_d;
      setup_cnt_q   <= setup_cnt_d;
      idle_cnt_q    <= idle_cnt_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    tx_req_d      = tx_req_q;
    tx_ack_d      = 1'b0;
    rx_req_d      = rx_req_q;
    rx_data_d     = rx_data_q;
    shift_start_d = 1'b0;
    shift_data_d  = shift_data_q;
    cs_n_d        = cs_n_q;
    xfer_count_d  = xfer_count_q;
    setup_cnt_d   = setup_cnt_q;
    idle_cnt_d    = idle_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (idle_cnt_q != '0) begin
          idle_cnt_d = idle_cnt_q - 1'b1;
        end else if (enable_i && !tx_empty_i) begin
          state_d  = S_FETCH;
          tx_req_d = 1'b1;
        end
      end
      S_FETCH: begin
        if (tx_resp_i) begin
          tx_req_d     = 1'b0;
          tx_ack_d     = 1'b1;
          shift_data_d = tx_data_i;
          state_d      = S_SETUP;
          // A chained word finds CS already low and skips the setup wait.
          if (cs_n_q) begin
            cs_n_d      = 1'b0;
            setup_cnt_d = '0;
          end else begin
            setup_cnt_d = SETUP_LAST;
          end
        end
      end
      S_SETUP: begin
        if (setup_cnt_q == SETUP_LAST) begin
          state_d       = S_START;
          shift_start_d = 1'b1;
        end else begin
          setup_cnt_d = setup_cnt_q + 1'b1;
        end
      end
      S_START: begin
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        if (shift_done_i) begin
          rx_data_d    = shift_data_i;
          rx_req_d     = 1'b1;
          xfer_count_d = xfer_count_q + 1'b1;
          state_d      = S_STORE;
        end
      end
      S_STORE: begin
        if (rx_ack_i) begin
          rx_req_d = 1'b0;
          state_d  = S_NEXT;
        end
      end
      S_NEXT: begin
        if (enable_i && cs_hold_i && !tx_empty_i) begin
          state_d  = S_FETCH;
          tx_req_d = 1'b1;
        end else begin
          state_d    = S_IDLE;
          cs_n_d     = 1'b1;
          idle_cnt_d = IDLE_LOAD;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  assign tx_req_o      = tx_req_q;
  assign tx_ack_o      = tx_ack_q;
  assign rx_req_o      = rx_req_q;
  assign rx_data_o     = rx_data_q;
  assign shift_start_o = shift_start_q;
  assign shift_data_o  = shift_data_q;
  assign cs_n_o        = cs_n_q;
  assign busy_o        = busy_q;
  assign xfer_count_o  = xfer_count_q;

endmodule

// File: tb/tb_spi_xfer_sequencer.sv
// Randomized bench for spi_xfer_sequencer: TX FIFO, shifter and RX FIFO agents
// plus a word-queue reference model of what must be shifted, pushed and counted.
module tb_spi_xfer_sequencer;
  localparam int DW = 16;
  localparam int RW = 4;
  localparam int CS_SETUP = 2;
  localparam int CS_IDLE  = 2;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          enable_i, cs_hold_i, tx_empty_i;
  logic          tx_req_o, tx_resp_i, tx_ack_o;
  logic [DW-1:0] tx_data_i;
  logic          rx_req_o, rx_ack_i;
  logic [DW-1:0] rx_data_o;
  logic          shift_start_o, shift_done_i;
  logic [DW-1:0] shift_data_o, shift_data_i;
  logic          cs_n_o, busy_o;
  logic [RW-1:0] xfer_count_o;

  spi_xfer_sequencer #(
    .DATA_WIDTH(DW), .REG_WIDTH(RW), .CS_SETUP(CS_SETUP), .CS_IDLE(CS_IDLE)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .enable_i(enable_i), .cs_hold_i(cs_hold_i),
    .tx_empty_i(tx_empty_i), .tx_req_o(tx_req_o), .tx_resp_i(tx_resp_i),
    .tx_data_i(tx_data_i), .tx_ack_o(tx_ack_o), .rx_req_o(rx_req_o),
    .rx_data_o(rx_data_o), .rx_ack_i(rx_ack_i), .shift_start_o(shift_start_o),
    .shift_data_o(shift_data_o), .shift_done_i(shift_done_i),
    .shift_data_i(shift_data_i), .cs_n_o(cs_n_o), .busy_o(busy_o),
    .xfer_count_o(xfer_count_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  // Reference model: words waiting in the TX FIFO, words that must appear on the
  // shifter in order, and words the RX FIFO must receive in order.
  logic [DW-1:0] tx_fifo[$];
  logic [DW-1:0] exp_shift[$];
  logic [DW-1:0] exp_rx[$];
  logic [DW-1:0] shift_resp_q[$];

  int done_words = 0, acks = 0, starts = 0, cs_rises = 0, cyc = 0;
  int low_run = 0, high_run = 0, ack_cyc = 0;
  int tx_wait = 1, tx_lat_cfg = 1;
  int shift_wait = 0, shift_lat_cfg = 8;
  int rx_wait = 0, rx_stall_cfg = 0;
  logic [DW-1:0] done_word = '0;
  bit cs_prev = 1'b1, chained = 1'b0, prev_ack = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Clamps a measured length to its minimum so a short run prints its real value.
  function automatic int atleast(input int v, input int m);
    return (v >= m) ? m : v;
  endfunction

  task automatic push_word(input logic [DW-1:0] w);
    tx_fifo.push_back(w);
    exp_shift.push_back(w);
  endtask

  task automatic wait_idle(input int target);
    int k = 0;
    while (!(done_words >= target && !busy_o && tx_fifo.size() == 0) && k < 3000) begin
      @(negedge clk_i);
      k++;
    end
    check("wait_idle_done", (k < 3000), 1);
    check("words_done", done_words, target);
    check("idle_cs_high", cs_n_o, 1'b1);
    check("idle_no_tx_req", tx_req_o, 1'b0);
  endtask

  // Agents and monitors, all acting on the falling edge.
  initial begin
    forever begin
      @(negedge clk_i);
      cyc++;

      if (!cs_n_o) begin
        if (cs_prev) check("cs_idle_gap", atleast(high_run, CS_IDLE), CS_IDLE);
        low_run++;
        high_run = 0;
      end else begin
        if (!cs_prev) cs_rises++;
        high_run++;
        low_run = 0;
      end
      cs_prev = cs_n_o;

      if (tx_ack_o) begin
        check("tx_ack_pulse", prev_ack, 1'b0);
        acks++;
        if (tx_fifo.size() > 0) void'(tx_fifo.pop_front());
        ack_cyc = cyc;
        chained = (low_run > 1);
      end
      prev_ack = tx_ack_o;

      if (shift_done_i) begin
        shift_done_i = 1'b0;
      end else if (shift_wait > 0) begin
        shift_wait--;
        if (shift_wait == 0) begin
          shift_done_i = 1'b1;
          shift_data_i = done_word;
        end
      end

      if (shift_start_o) begin
        starts++;
        if (exp_shift.size() == 0) check("shift_unexpected", 1, 0);
        else check("shift_data", shift_data_o, exp_shift.pop_front());
        check("cs_setup", atleast(low_run - 1, CS_SETUP), CS_SETUP);
        if (chained) check("chain_nowait", (cyc - ack_cyc <= 1), 1);
        done_word = (shift_resp_q.size() > 0) ? shift_resp_q.pop_front() : DW'($urandom);
        exp_rx.push_back(done_word);
        shift_wait = (shift_lat_cfg > 0) ? shift_lat_cfg : int'($urandom_range(1, 10));
      end

      if (rst_i) begin
        tx_resp_i = 1'b0;
      end else if (tx_resp_i) begin
        tx_resp_i = 1'b0;
        check("tx_req_drop", tx_req_o, 1'b0);
      end else if (tx_req_o) begin
        if (tx_wait > 0) begin
          tx_wait--;
        end else if (tx_fifo.size() == 0) begin
          check("tx_underflow", 1, 0);
        end else begin
          tx_resp_i = 1'b1;
          tx_data_i = tx_fifo[0];
          tx_wait = (tx_lat_cfg < 0) ? int'($urandom_range(0, 2)) : tx_lat_cfg;
        end
      end
      tx_empty_i = (tx_fifo.size() == 0);

      if (rst_i) begin
        rx_ack_i = 1'b0;
      end else if (rx_ack_i) begin
        rx_ack_i = 1'b0;
        check("rx_req_drop", rx_req_o, 1'b0);
      end else if (rx_req_o) begin
        if (rx_wait > 0) begin
          rx_wait--;
          check("stall_no_fetch", tx_req_o, 1'b0);
          check("stall_cs_low", cs_n_o, 1'b0);
        end else begin
          rx_ack_i = 1'b1;
          done_words++;
          if (exp_rx.size() == 0) check("rx_unexpected", 1, 0);
          else check("rx_data", rx_data_o, exp_rx.pop_front());
          check("xfer_count", xfer_count_o, done_words % (1 << RW));
          $display("rx push data=0x%04h count=%0d", rx_data_o, xfer_count_o);
          rx_wait = (rx_stall_cfg < 0) ? int'($urandom_range(0, 3)) : rx_stall_cfg;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got time limit, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0, s0, total, n, k;
    rst_i = 1'b1; enable_i = 1'b0; cs_hold_i = 1'b0; tx_empty_i = 1'b1;
    tx_resp_i = 1'b0; tx_data_i = '0; rx_ack_i = 1'b0;
    shift_done_i = 1'b0; shift_data_i = '0;
    repeat (3) @(negedge clk_i);
    check("rst_cs_n", cs_n_o, 1'b1);
    check("rst_tx_req", tx_req_o, 1'b0);
    check("rst_tx_ack", tx_ack_o, 1'b0);
    check("rst_rx_req", rx_req_o, 1'b0);
    check("rst_rx_data", rx_data_o, 0);
    check("rst_shift_start", shift_start_o, 1'b0);
    check("rst_shift_data", shift_data_o, 0);
    check("rst_busy", busy_o, 1'b0);
    check("rst_count", xfer_count_o, 0);
    rst_i = 1'b0;

    // Single word with fixed latencies.
    push_word(16'hA5C3);
    shift_resp_q.push_back(16'h1234);
    enable_i = 1'b1;
    wait_idle(1);
    check("single_acks", acks, 1);
    check("single_count", xfer_count_o, 1);

    // Held-CS burst echoing each word back.
    cs_hold_i = 1'b1;
    r0 = cs_rises;
    for (int i = 1; i <= 3; i++) begin
      push_word(DW'(i));
      shift_resp_q.push_back(DW'(i));
    end
    wait_idle(4);
    check("hold_cs_rises", cs_rises - r0, 1);
    check("hold_count", xfer_count_o, 4);

    // Two words without CS hold: CS must release between them.
    cs_hold_i = 1'b0;
    shift_lat_cfg = 0;
    r0 = cs_rises;
    for (int i = 0; i < 2; i++) push_word(DW'($urandom));
    wait_idle(6);
    check("nohold_cs_rises", cs_rises - r0, 2);

    // RX backpressure of 20 cycles per word on a held-CS pair.
    cs_hold_i = 1'b1;
    tx_lat_cfg = -1;
    rx_stall_cfg = 20;
    rx_wait = 20;
    for (int i = 0; i < 2; i++) push_word(DW'($urandom));
    wait_idle(8);
    rx_stall_cfg = 0;
    rx_wait = 0;

    // Reset while shifting: the late shift_done must not reach the RX FIFO.
    cs_hold_i = 1'b0;
    shift_lat_cfg = 15;
    s0 = starts;
    push_word(DW'($urandom));
    k = 0;
    while (starts == s0 && k < 200) begin
      @(negedge clk_i);
      k++;
    end
    check("rst_test_started", (starts > s0), 1);
    repeat (3) @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    check("midrst_cs_n", cs_n_o, 1'b1);
    check("midrst_busy", busy_o, 1'b0);
    check("midrst_count", xfer_count_o, 0);
    check("midrst_tx_req", tx_req_o, 1'b0);
    rst_i = 1'b0;
    enable_i = 1'b0;
    exp_rx.delete();
    done_words = 0;
    repeat (25) @(negedge clk_i);
    check("postrst_no_push", done_words, 0);
    check("postrst_rx_req", rx_req_o, 1'b0);

    // Random batches totalling 17 words; the 4-bit counter wraps to 1.
    enable_i = 1'b1;
    shift_lat_cfg = 0;
    rx_stall_cfg = -1;
    total = 0;
    while (total < 17) begin
      n = $urandom_range(1, 4);
      if (total + n > 17) n = 17 - total;
      cs_hold_i = 1'($urandom_range(0, 1));
      for (int i = 0; i < n; i++) push_word(DW'($urandom));
      total += n;
      wait_idle(total);
    end
    check("wrap_count", xfer_count_o, 1);
    check("total_acks", acks, 26);
    check("total_starts", starts, 26);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
